// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter family.
//
// Contents:
//   COUNTER_WIDTH_DEF, SYNC_STAGES_DEF : default widths for counters and synchronisers
//   GRAY_MAX_W                         : widest count the helpers accept
//   gray2bin / bin2gray                : code conversions
//   hamming_gt1                        : true when two codes differ in more than one bit
//
// The helpers work on zero-extended GRAY_MAX_W-bit operands. Zero bits above the real
// width do not change either conversion. Callers therefore cast in and out at their own
// width, which keeps one function body valid for every counter width.
package gray_pkg;

  localparam int unsigned COUNTER_WIDTH_DEF = 3;
  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned GRAY_MAX_W        = 32;

  // Each binary bit is the XOR of its own Gray bit and every more-significant Gray bit.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // x & (x - 1) clears the lowest set bit; anything left means two or more bits differ.
  function automatic logic hamming_gt1(input logic [GRAY_MAX_W-1:0] a,
                                       input logic [GRAY_MAX_W-1:0] b);
    logic [GRAY_MAX_W-1:0] diff;
    diff = a ^ b;
    return (diff & (diff - 1)) != '0;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded bus crossing into the local clock domain.
//
// Parameters: WIDTH (bus width), STAGES (flop depth, at least 2).
// Ports:
//   clk_i  : destination-domain clock
//   rst_ni : asynchronous active-low reset, clears every stage
//   d_i    : asynchronous Gray input
//   q_o    : output of the last stage
module gray_sync
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = COUNTER_WIDTH_DEF,
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_d [STAGES];
  logic [WIDTH-1:0] stage_q [STAGES];

  always_comb begin
    stage_d[0] = d_i;
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gray_pointer_decoder.sv
// Receive side of an async-FIFO pointer: synchronises a remote Gray count, decodes it to
// binary and tracks a local consumer count against it.
//
// Optional build macro GRAY_POINTER_ERR_CHECK_EN adds a sticky detector for synchronised
// Gray steps that change more than one bit. Without it Error_out is tied low.
//
// Ports:
//   Clk             : local clock
//   Reset_n_in      : asynchronous active-low reset
//   GrayCount_in    : remote Gray count, asynchronous to Clk
//   Enable_in       : consume one entry when not empty
//   Clear_in        : synchronous clear of local count and error flag (wins over Enable_in)
//   BinaryCount_out : registered binary decode of the synchronised remote count
//   LocalCount_out  : local consumer count
//   Level_out       : BinaryCount_out - LocalCount_out, modulo 2^COUNTER_WIDTH
//   Empty_out       : Level_out == 0
//   Error_out       : sticky illegal-transition flag
module gray_pointer_decoder
  import gray_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = COUNTER_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset_n_in,
  input  logic [COUNTER_WIDTH-1:0] GrayCount_in,
  input  logic                     Enable_in,
  input  logic                     Clear_in,
  output logic [COUNTER_WIDTH-1:0] BinaryCount_out,
  output logic [COUNTER_WIDTH-1:0] LocalCount_out,
  output logic [COUNTER_WIDTH-1:0] Level_out,
  output logic                     Empty_out,
  output logic                     Error_out
);

  logic [COUNTER_WIDTH-1:0] sync_gray;
  logic [COUNTER_WIDTH-1:0] binary_count_d, binary_count_q;
  logic [COUNTER_WIDTH-1:0] local_count_d, local_count_q;
  logic [COUNTER_WIDTH-1:0] level;
  logic                     empty;

  gray_sync #(
    .WIDTH  (COUNTER_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (Clk),
    .rst_ni (Reset_n_in),
    .d_i    (GrayCount_in),
    .q_o    (sync_gray)
  );

  always_comb begin
    binary_count_d = COUNTER_WIDTH'(gray2bin(GRAY_MAX_W'(sync_gray)));
  end

  // Wrap-around is implicit in the truncated subtraction.
  assign level = binary_count_q - local_count_q;
  assign empty = (level == '0);

  // Enable is judged on the emptiness seen before this edge, so an entry that arrives
  // on the same edge is only consumable on the next cycle.
  always_comb begin
    local_count_d = local_count_q;
    if (Clear_in) begin
      local_count_d = '0;
    end else if (Enable_in && !empty) begin
      local_count_d = local_count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      binary_count_q <= '0;
      local_count_q  <= '0;
    end else begin
      binary_count_q <= binary_count_d;
      local_count_q  <= local_count_d;
    end
  end

`ifdef GRAY_POINTER_ERR_CHECK_EN
  logic [COUNTER_WIDTH-1:0] prev_gray_d, prev_gray_q;
  logic                     error_d, error_q;

  // Compares the value now in the last sync stage with the one it replaced, so a bad
  // step is flagged on the edge after it lands in the last stage.
  always_comb begin
    prev_gray_d = sync_gray;
    error_d     = error_q;
    if (Clear_in) begin
      error_d = 1'b0;
    end else if (hamming_gt1(GRAY_MAX_W'(prev_gray_q), GRAY_MAX_W'(sync_gray))) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      prev_gray_q <= '0;
      error_q     <= 1'b0;
    end else begin
      prev_gray_q <= prev_gray_d;
      error_q     <= error_d;
    end
  end

  assign Error_out = error_q;
`else
  assign Error_out = 1'b0;
`endif

  assign BinaryCount_out = binary_count_q;
  assign LocalCount_out  = local_count_q;
  assign Level_out       = level;
  assign Empty_out       = empty;

endmodule

// File: doc/gray_pointer_decoder.md
Name: gray_pointer_decoder

Overview:
- Receive-side companion to the team's Gray-code counter. It accepts a Gray-coded count produced in another clock domain, synchronises it, and decodes it back to binary.
- It tracks a local binary consumer count against the decoded remote count and reports level and empty status.
- It is used as the read-pointer side of the WM8731 audio-sample async FIFOs.

Parameters:
- COUNTER_WIDTH, 3: width of the Gray input and of all counts; minimum 2.
- SYNC_STAGES, 2: number of synchroniser flops on GrayCount_in; minimum 2.

Ports:
- Clk  input  1  local-domain clock; all state changes on the rising edge.
- Reset_n_in  input  1  asynchronous, active-low reset.
- GrayCount_in  input  COUNTER_WIDTH  Gray count from the remote counter; asynchronous to Clk.
- Enable_in  input  1  consume request; advances the local count when not empty.
- Clear_in  input  1  synchronous clear of local count and error flag; takes precedence over Enable_in.
- BinaryCount_out  output  COUNTER_WIDTH  registered binary decode of the synchronised remote count.
- LocalCount_out  output  COUNTER_WIDTH  local binary consumer count.
- Level_out  output  COUNTER_WIDTH  (BinaryCount_out - LocalCount_out) mod 2^COUNTER_WIDTH.
- Empty_out  output  1  high when Level_out == 0.
- Error_out  output  1  sticky flag for an illegal Gray transition; see Optional Feature.

Behaviour:
- Reset (Reset_n_in=0, asynchronous):
  - All synchroniser flops, BinaryCount_out, LocalCount_out and Error_out go to 0.
  - Level_out=0, Empty_out=1.
  - Reset asserted mid-operation aborts everything immediately; no partial state survives.
- Synchroniser:
  - GrayCount_in passes through SYNC_STAGES flops in series; the last stage is sync_gray.
  - The flops are not reset by Clear_in.
- Decode:
  - b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i] for i = W-2 down to 0.
  - The result is registered into BinaryCount_out.
- Latency: a GrayCount_in change that meets setup before edge 1 appears on BinaryCount_out after edge SYNC_STAGES+1 (3 cycles by default).
- Level_out and Empty_out:
  - Combinational from BinaryCount_out and LocalCount_out; no added latency.
  - Subtraction is modulo 2^COUNTER_WIDTH, so wrap-around is implicit.
- Local count, per edge, in priority order:
  - Clear_in=1: LocalCount_out <= 0 and Error_out <= 0.
  - Otherwise, Enable_in=1 and Empty_out=0: LocalCount_out <= LocalCount_out + 1, wrapping from 2^W-1 to 0.
  - Otherwise, Enable_in=1 and Empty_out=1: request ignored; no underflow.
- Simultaneous events: if the remote count advances on the same edge as Enable_in, the enable is judged on Empty_out before that edge. A newly arrived entry is consumable on the following cycle.
- Clear_in does not touch BinaryCount_out, so Level_out after a clear equals the decoded remote count.
- Full is not detected here. The writer guarantees it never runs ahead of the reader by 2^W or more.

Optional Feature:
- Macro: GRAY_POINTER_ERR_CHECK_EN.
- When defined:
  - One extra register holds the previous sync_gray.
  - If the Hamming distance between consecutive sync_gray values is greater than 1, Error_out <= 1.
  - Error_out is sticky until Clear_in or reset.
  - Detection is reported one cycle after the offending value reaches the last sync stage.
- When not defined: Error_out is tied to 0 and the extra register is absent.

Decomposition:
- Shared package gray_pkg:
  - gray2bin and bin2gray functions, parameterised by width.
  - A hamming_gt1 helper function.
  - The default widths COUNTER_WIDTH_DEF=3 and SYNC_STAGES_DEF=2.
- One natural sub-module, gray_sync: an SYNC_STAGES-deep, COUNTER_WIDTH-wide flop chain with asynchronous active-low reset.
- Decode, local counter and error check stay in the top module.

Test Plan:
- Reset: assert Reset_n_in=0 mid-count with local=5 -> all counts 0, Level_out=0, Empty_out=1, Error_out=0, with no clock edge needed.
- Latency: GrayCount_in 000->001 before edge 1 -> BinaryCount_out=1 after edge 3; Level_out=1, Empty_out=0.
- Decode sweep: GrayCount_in 000,001,011,010,110,111,101,100, one per cycle -> BinaryCount_out 0..7 in order, each 3 cycles after its input.
- Underflow / simultaneous: Empty_out=1, hold Enable_in=1 -> LocalCount_out stays 0. Then remote goes to 1 -> local goes to 1 on the edge after Empty_out falls, and Empty_out returns to 1.
- Wrap: remote=7 (Gray 100), local=7, then Gray 000 -> Level_out=1; one Enable_in -> local=0, Empty_out=1.
- Error (macro defined): GrayCount_in 000->011 -> Error_out=1 one cycle after the value reaches the last sync stage, held through further legal steps; Clear_in=1 -> Error_out=0. With the macro undefined, the same stimulus leaves Error_out=0.
